// File: rtl/lcd_bcd_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lcd_bcd_driver_if                                          |
// | Purpose : Host-side request/acknowledge bundle for lcd_bcd_driver.   |
// |           The application drives digits/upd_req and observes        |
// |           upd_ack/busy.                                              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface lcd_bcd_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    upd_req;
  logic                    upd_ack;
  logic                    busy;

  modport master (
    output digits,
    output upd_req,
    input  upd_ack,
    input  busy
  );

  modport slave (
    input  digits,
    input  upd_req,
    output upd_ack,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/lcd_bcd_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lcd_bcd_driver                                             |
// | Purpose : HD44780 4-bit-mode controller. Powers up and initialises   |
// |           the panel, then on request writes NUM_DIGITS BCD digits    |
// |           starting at column START_COL of line 1.                    |
// | Options : define LCD_HEX_EN to show digit values 10..15 as 'A'..'F'; |
// |           otherwise they are shown as '-'.                           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lcd_bcd_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int START_COL      = 0,
  parameter int E_PULSE_CYC    = 12,
  parameter int NIB_GAP_CYC    = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLR_WAIT_CYC   = 82000,
  parameter int INIT_WAIT_CYC  = 205000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  lcd_bcd_driver_if.slave  host,
  output logic             sf_e,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d
);

  localparam int M1 = (E_PULSE_CYC   > NIB_GAP_CYC)    ? E_PULSE_CYC   : NIB_GAP_CYC;
  localparam int M2 = (CMD_WAIT_CYC  > CLR_WAIT_CYC)   ? CMD_WAIT_CYC  : CLR_WAIT_CYC;
  localparam int M3 = (INIT_WAIT_CYC > PWRUP_WAIT_CYC) ? INIT_WAIT_CYC : PWRUP_WAIT_CYC;
  localparam int M4 = (M1 > M2) ? M1 : M2;
  localparam int MAX_WAIT = (M4 > M3) ? M4 : M3;
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam int IW = 5;

  // Terminal counts: a wait of N cycles ends when the counter reads N-1.
  localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(NIB_GAP_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_WAIT_CYC - 1);
  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    PWRUP, INIT_NIB, INIT_WAIT, CMD, IDLE, UPD
  } state_t;

  // Sub-phases of one byte/nibble transfer.
  typedef enum logic [2:0] {
    P_LOAD, P_SETUP, P_HIGH, P_GAP, P_POST
  } phase_t;

  state_t                  state;
  phase_t                  ph;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    lo;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    ack_reg;
  logic                    busy_reg;

  logic [7:0]              cur_byte;
  logic                    cur_rs;
  logic                    last_byte;
  logic [CW-1:0]           post_last;

  assign host.upd_ack = ack_reg;
  assign host.busy    = busy_reg;

  function automatic logic [7:0] to_ascii(input logic [3:0] v);
    if (v <= 4'd9)
      to_ascii = 8'h30 | {4'h0, v};
`ifdef LCD_HEX_EN
    else
      to_ascii = 8'h37 + {4'h0, v};
`else
    else
      to_ascii = 8'h2D;
`endif
  endfunction

  // Byte selected by the sequencer index: init commands in CMD, address then digits in UPD.
  always_comb begin
    cur_byte = 8'h00;
    if (state == CMD) begin
      case (idx[1:0])
        2'd0:    cur_byte = 8'h28;
        2'd1:    cur_byte = 8'h06;
        2'd2:    cur_byte = 8'h0C;
        default: cur_byte = 8'h01;
      endcase
    end else if (idx == '0) begin
      cur_byte = 8'h80 | 8'(START_COL);
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i + 1))
          cur_byte = to_ascii(shadow[4*(NUM_DIGITS-1-i) +: 4]);
      end
    end
    cur_rs    = (state == UPD) && (idx != '0);
    last_byte = (state == CMD) ? (idx == IW'(3)) : (idx == IW'(NUM_DIGITS));
    // Clear-display needs the long wait; every other byte uses the short one.
    post_last = ((state == CMD) && (idx == IW'(3))) ? CLR_LAST : CMD_LAST;
  end

  // Main controller: power-up, init nibbles, byte sequencing and host handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWRUP;
      ph       <= P_LOAD;
      cnt      <= '0;
      idx      <= '0;
      lo       <= 1'b0;
      shadow   <= '0;
      sf_e     <= 1'b1;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_d    <= 4'h0;
      busy_reg <= 1'b1;
      ack_reg  <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      sf_e    <= 1'b1;
      lcd_rw  <= 1'b0;
      case (state)
        PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt    <= '0;
            idx    <= '0;
            lcd_rs <= 1'b0;
            lcd_d  <= 4'h3;
            ph     <= P_SETUP;
            state  <= INIT_NIB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        INIT_NIB: begin
          case (ph)
            P_SETUP: begin
              lcd_e <= 1'b1;
              cnt   <= '0;
              ph    <= P_HIGH;
            end
            P_HIGH: begin
              if (cnt == E_LAST) begin
                lcd_e <= 1'b0;
                cnt   <= '0;
                state <= INIT_WAIT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: ph <= P_SETUP;
          endcase
        end

        INIT_WAIT: begin
          if (cnt == INIT_LAST) begin
            cnt <= '0;
            if (idx == IW'(3)) begin
              idx   <= '0;
              ph    <= P_LOAD;
              state <= CMD;
            end else begin
              // Three 0x3 wake-up nibbles, then 0x2 selects 4-bit mode.
              lcd_d <= (idx == IW'(2)) ? 4'h2 : 4'h3;
              idx   <= idx + 1'b1;
              ph    <= P_SETUP;
              state <= INIT_NIB;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CMD, UPD: begin
          case (ph)
            P_LOAD: begin
              lcd_rs   <= cur_rs;
              lcd_d    <= cur_byte[7:4];
              lo       <= 1'b0;
              busy_reg <= 1'b1;
              if ((state == UPD) && (idx == '0))
                ack_reg <= 1'b1;
              ph <= P_SETUP;
            end
            P_SETUP: begin
              lcd_e <= 1'b1;
              cnt   <= '0;
              ph    <= P_HIGH;
            end
            P_HIGH: begin
              if (cnt == E_LAST) begin
                lcd_e <= 1'b0;
                cnt   <= '0;
                ph    <= lo ? P_POST : P_GAP;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            P_GAP: begin
              if (cnt == GAP_LAST) begin
                lcd_d <= cur_byte[3:0];
                lo    <= 1'b1;
                cnt   <= '0;
                ph    <= P_SETUP;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              if (cnt == post_last) begin
                cnt <= '0;
                if (last_byte) begin
                  busy_reg <= 1'b0;
                  state    <= IDLE;
                end else begin
                  idx <= idx + 1'b1;
                  ph  <= P_LOAD;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          endcase
        end

        IDLE: begin
          busy_reg <= 1'b0;
          if (host.upd_req) begin
            shadow <= host.digits;
            idx    <= '0;
            cnt    <= '0;
            ph     <= P_LOAD;
            state  <= UPD;
          end
        end

        default: begin
          cnt   <= '0;
          state <= PWRUP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bcd_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_lcd_bcd_driver                                          |
// | Purpose : Scoreboard bench for lcd_bcd_driver. Expected LCD nibbles  |
// |           are queued when a request is issued; a monitor pops one    |
// |           entry per lcd_e falling edge.                              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_lcd_bcd_driver;
  localparam int ND        = 4;
  localparam int START_COL = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  int         n_chk      = 0;
  int         n_pass     = 0;
  int         ack_cycles = 0;
  int         pin_bad    = 0;
  int         hi_cnt     = 0;
  logic       prev_e     = 1'b0;
  logic [4:0] exp_q[$];

  lcd_bcd_driver_if #(.NUM_DIGITS(ND)) host ();

  lcd_bcd_driver #(
    .NUM_DIGITS(ND), .START_COL(START_COL), .E_PULSE_CYC(2), .NIB_GAP_CYC(3),
    .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(10), .INIT_WAIT_CYC(8), .PWRUP_WAIT_CYC(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(host), .sf_e(sf_e), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: character code for one digit value.
  function automatic logic [7:0] ascii(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
`ifdef LCD_HEX_EN
    return 8'h41 + {4'h0, v} - 8'd10;
`else
    return 8'h2D;
`endif
  endfunction

  function automatic void push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endfunction

  function automatic void push_init();
    logic [7:0] cmds[4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
    exp_q.push_back(5'h03); exp_q.push_back(5'h03);
    exp_q.push_back(5'h03); exp_q.push_back(5'h02);
    foreach (cmds[i]) push_byte(1'b0, cmds[i]);
  endfunction

  function automatic void push_update(input logic [15:0] v);
    push_byte(1'b0, 8'h80 + 8'(START_COL));
    for (int i = 0; i < ND; i++) push_byte(1'b1, ascii(v[4*(ND-1-i) +: 4]));
  endfunction

  // Monitor: pin invariants, ack pulses and one scoreboard pop per lcd_e fall.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_e = 1'b0;
        hi_cnt = 0;
      end else begin
        if (sf_e !== 1'b1 || lcd_rw !== 1'b0) pin_bad++;
        if (host.upd_ack === 1'b1) ack_cycles++;
        if (lcd_e === 1'b1) begin
          hi_cnt++;
        end else if (prev_e) begin
          check("e_width", 32'(hi_cnt), 32'd2);
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_strobe: got rs=%0b d=%0h expected no strobe", lcd_rs, lcd_d);
          end else begin
            check("nibble", 32'({lcd_rs, lcd_d}), 32'(exp_q.pop_front()));
          end
          hi_cnt = 0;
        end
        prev_e = lcd_e;
      end
    end
  end

  task automatic wait_idle(input string name);
    int k = 0;
    while (host.busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(host.busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Issue a one-cycle request and check the handshake timing around it.
  task automatic start_req(input logic [15:0] v);
    host.digits = v;
    push_update(v);
    host.upd_req = 1'b1;
    @(negedge clk);
    host.upd_req = 1'b0;
    check("ack_not_early", 32'(host.upd_ack), 32'd0);
    @(negedge clk);
    check("ack_pulse", 32'(host.upd_ack), 32'd1);
    check("busy_on_ack", 32'(host.busy), 32'd1);
    check("addr_hi_setup", 32'({lcd_rs, lcd_d}), 32'h08);
    check("e_low_setup", 32'(lcd_e), 32'd0);
    @(negedge clk);
    check("ack_single", 32'(host.upd_ack), 32'd0);
    check("e_rise", 32'(lcd_e), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int k;
    int low;
    logic [31:0] r;
    host.upd_req = 1'b0;
    host.digits  = '0;
    repeat (3) @(negedge clk);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs_d", 32'({lcd_rs, lcd_d}), 32'd0);
    check("rst_busy", 32'(host.busy), 32'd1);
    check("rst_ack", 32'(host.upd_ack), 32'd0);
    check("rst_sf_rw", 32'({sf_e, lcd_rw}), 32'h2);

    // Power-up and init sequence.
    push_init();
    rst_n = 1'b1;
    @(negedge clk);
    check("busy_during_init", 32'(host.busy), 32'd1);
    wait_idle("init_done");

    // Directed update.
    a0 = ack_cycles;
    start_req(16'h1905);
    wait_idle("upd_1905");
    check("ack_count_1905", 32'(ack_cycles - a0), 32'd1);

    // Digits changed after capture.
    a0 = ack_cycles;
    start_req(16'h1905);
    host.digits = 16'h7777;
    wait_idle("upd_shadow");
    check("ack_count_shadow", 32'(ack_cycles - a0), 32'd1);

    // Request held high across two updates.
    a0 = ack_cycles;
    host.digits = 16'h4321;
    push_update(16'h4321);
    push_update(16'h4321);
    host.upd_req = 1'b1;
    k = 0;
    while (host.upd_ack !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    k = 0;
    while (host.busy !== 1'b0 && k < 3000) begin @(negedge clk); k++; end
    low = 0;
    while (host.busy === 1'b0 && low < 50) begin low++; @(negedge clk); end
    check("busy_gap_seen", 32'(low >= 1), 32'd1);
    check("second_started", 32'(host.busy), 32'd1);
    k = 0;
    while (host.upd_ack !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    host.upd_req = 1'b0;
    wait_idle("upd_hold");
    check("ack_count_hold", 32'(ack_cycles - a0), 32'd2);

    // Pulse during busy is ignored.
    a0 = ack_cycles;
    start_req(16'h2468);
    repeat (6) @(negedge clk);
    host.upd_req = 1'b1;
    @(negedge clk);
    host.upd_req = 1'b0;
    wait_idle("upd_ignore");
    check("ack_count_ignore", 32'(ack_cycles - a0), 32'd1);

    // Hex/dash mapping boundaries.
    start_req(16'hA00F);
    wait_idle("upd_a00f");

    // Randomised updates.
    for (int i = 0; i < 4; i++) begin
      a0 = ack_cycles;
      r  = $urandom;
      start_req(r[15:0]);
      wait_idle("upd_rand");
      check("ack_count_rand", 32'(ack_cycles - a0), 32'd1);
    end

    // Reset in the middle of a data strobe.
    start_req(16'h5678);
    k = 0;
    while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && k < 500) begin @(negedge clk); k++; end
    check("pre_reset_e", 32'(lcd_e), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_e_async", 32'(lcd_e), 32'd0);
    check("reset_busy", 32'(host.busy), 32'd1);
    check("reset_rs_d", 32'({lcd_rs, lcd_d}), 32'd0);
    check("reset_ack", 32'(host.upd_ack), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    wait_idle("reinit_done");

    check("sf_e_rw_stable", 32'(pin_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
